vpu_core_seq: RTL

- Clocked, parametrised successor to the team's combinational vector-processing-unit datapath.
- Accepts 32-bit instructions over a valid/ready handshake and executes them against a resettable GPR file and the special register SGPR.
- Keeps the existing instruction encoding and opcode set; adds a registered flag set, an iterative multi-cycle multiplier, illegal-opcode detection and a debug read port.
- Sits between the instruction sequencer (upstream) and the trace/debug logic (downstream).

---
 rtl/vpu_pkg.sv | 42 ++++
 rtl/vpu_mul_seq.sv | 69 ++++++
 rtl/vpu_core_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared definitions for the sequential vector-processing-unit core:
// opcodes, instruction field positions, flag bit indices and FSM states.
package vpu_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_OR      = 5'd5;
   localparam logic [4:0] OP_AND     = 5'd6;
   localparam logic [4:0] OP_XOR     = 5'd7;
   localparam logic [4:0] OP_XNOR    = 5'd8;
   localparam logic [4:0] OP_NAND    = 5'd9;
   localparam logic [4:0] OP_NOR     = 5'd10;
   localparam logic [4:0] OP_NOT     = 5'd11;

   localparam int OP_MSB       = 31;
   localparam int OP_LSB       = 27;
   localparam int RDST_MSB     = 26;
   localparam int RDST_LSB     = 22;
   localparam int RS1_MSB      = 21;
   localparam int RS1_LSB      = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RS2_MSB      = 15;
   localparam int RS2_LSB      = 11;
   localparam int IMM_MSB      = 15;
   localparam int IMM_LSB      = 0;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RET  = 2'd3
   } vpu_state_e;

endpackage

// File: rtl/vpu_mul_seq.sv
// Iterative unsigned shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done_o and product_o are valid combinationally during the final step.
module vpu_mul_seq
   import vpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MUL_STEP = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [2*DATA_W-1:0] product_o
);
   localparam int NSTEP = DATA_W / MUL_STEP;
   localparam int CNT_W = $clog2(NSTEP + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

   logic                       busy_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [DATA_W-1:0]          a_q, hi_q, lo_q;

   logic                       active, last;
   logic [CNT_W-1:0]           cnt_cur;
   logic [DATA_W-1:0]          a_cur, hi_cur, lo_cur;
   logic [DATA_W+MUL_STEP-1:0] partial, sum;

   // Start takes operands straight from the inputs so the first step needs no load cycle.
   always_comb begin
      active = start_i | busy_q;
      if (start_i) begin
         a_cur   = a_i;
         hi_cur  = '0;
         lo_cur  = b_i;
         cnt_cur = '0;
      end else begin
         a_cur   = a_q;
         hi_cur  = hi_q;
         lo_cur  = lo_q;
         cnt_cur = cnt_q;
      end
      partial   = {{MUL_STEP{1'b0}}, a_cur} * {{DATA_W{1'b0}}, lo_cur[MUL_STEP-1:0]};
      sum       = {{MUL_STEP{1'b0}}, hi_cur} + partial;
      product_o = {sum, lo_cur[DATA_W-1:MUL_STEP]};
      last      = (cnt_cur == LAST);
      done_o    = active & last;
      busy_o    = busy_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         a_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else if (active) begin
         a_q    <= a_cur;
         hi_q   <= product_o[2*DATA_W-1:DATA_W];
         lo_q   <= product_o[DATA_W-1:0];
         cnt_q  <= cnt_cur + 1'b1;
         busy_q <= ~last;
      end
   end

endmodule

// File: rtl/vpu_core_seq.sv
// Clocked VPU core: one instruction at a time over valid/ready, GPR file, SGPR,
// registered flags, iterative multiply, illegal detection and a debug read port.
module vpu_core_seq
   import vpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_GPR  = 32,
   parameter int MUL_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr_data,
   output logic              done,
   output logic              illegal,
   output logic [3:0]        flags,
   output logic [DATA_W-1:0] sgpr,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int IDX_W = $clog2(NUM_GPR);

   // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
   // instr_ready is high only in IDLE and instr_data is ignored otherwise.
   vpu_state_e        state_q;
   logic [31:0]       ir_q;
   logic              ready_q, done_q, illegal_q;
   logic [3:0]        flags_q;
   logic [DATA_W-1:0] sgpr_q;
   logic [DATA_W-1:0] gpr_q [NUM_GPR];

   logic [4:0]        ir_op, ir_rdst, ir_rs1, ir_rs2;
   logic              ir_imm_mode, ir_legal;
   logic [DATA_W-1:0] imm_ext, op_a, op_b, wb_data_d;
   logic [DATA_W:0]   sum_w;
   logic              carry, ovf;
   logic [3:0]        flags_d;

   logic                mul_start, mul_busy, mul_done;
   logic [2*DATA_W-1:0] mul_prod;

   function automatic logic idx_ok(input logic [4:0] idx);
      return int'(idx) < NUM_GPR;
   endfunction

   // Only fields an opcode actually reads are range-checked; in imm mode rsrc2 is immediate bits.
   function automatic logic instr_legal(input logic [31:0] w);
      logic [4:0] op;
      logic       im, ok;
      op = w[OP_MSB:OP_LSB];
      im = w[IMM_MODE_BIT];
      ok = (op <= OP_NOT) && idx_ok(w[RDST_MSB:RDST_LSB]);
      if (op != OP_MOVSGPR && !(im && (op == OP_MOV || op == OP_NOT)))
         ok = ok && idx_ok(w[RS1_MSB:RS1_LSB]);
      if (!im && (op inside {OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR}))
         ok = ok && idx_ok(w[RS2_MSB:RS2_LSB]);
      return ok;
   endfunction

   assign ir_op       = ir_q[OP_MSB:OP_LSB];
   assign ir_rdst     = ir_q[RDST_MSB:RDST_LSB];
   assign ir_rs1      = ir_q[RS1_MSB:RS1_LSB];
   assign ir_rs2      = ir_q[RS2_MSB:RS2_LSB];
   assign ir_imm_mode = ir_q[IMM_MODE_BIT];
   assign imm_ext     = {{(DATA_W-16){1'b0}}, ir_q[IMM_MSB:IMM_LSB]};
   assign ir_legal    = instr_legal(ir_q);

   always_comb begin
      op_a      = gpr_q[ir_rs1[IDX_W-1:0]];
      op_b      = ir_imm_mode ? imm_ext : gpr_q[ir_rs2[IDX_W-1:0]];
      sum_w     = '0;
      carry     = 1'b0;
      ovf       = 1'b0;
      wb_data_d = '0;
      case (ir_op)
         OP_MOVSGPR: wb_data_d = sgpr_q;
         OP_MOV:     wb_data_d = ir_imm_mode ? imm_ext : op_a;
         OP_ADD: begin
            sum_w     = {1'b0, op_a} + {1'b0, op_b};
            wb_data_d = sum_w[DATA_W-1:0];
            carry     = sum_w[DATA_W];
            ovf       = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (wb_data_d[DATA_W-1] != op_a[DATA_W-1]);
         end
         OP_SUB: begin
            wb_data_d = op_a - op_b;
            carry     = (op_a < op_b);
            ovf       = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (wb_data_d[DATA_W-1] != op_a[DATA_W-1]);
         end
         OP_OR:      wb_data_d = op_a | op_b;
         OP_AND:     wb_data_d = op_a & op_b;
         OP_XOR:     wb_data_d = op_a ^ op_b;
         OP_XNOR:    wb_data_d = ~(op_a ^ op_b);
         OP_NAND:    wb_data_d = ~(op_a & op_b);
         OP_NOR:     wb_data_d = ~(op_a | op_b);
         OP_NOT:     wb_data_d = ir_imm_mode ? ~imm_ext : ~op_a;
         default:    wb_data_d = '0;
      endcase
      flags_d         = '0;
      flags_d[FLAG_N] = wb_data_d[DATA_W-1];
      flags_d[FLAG_Z] = (wb_data_d == '0);
      flags_d[FLAG_C] = carry;
      flags_d[FLAG_V] = ovf;
   end

   // The multiplier is idle only on the first MUL cycle, which is when operands are sampled.
   assign mul_start = (state_q == ST_MUL) && !mul_busy;

   vpu_mul_seq #(
      .DATA_W   (DATA_W),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         flags_q   <= '0;
         sgpr_q    <= '0;
         for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_valid && ready_q) begin
                  ir_q    <= instr_data;
                  ready_q <= 1'b0;
                  if (instr_data[OP_MSB:OP_LSB] == OP_MUL && instr_legal(instr_data))
                     state_q <= ST_MUL;
                  else
                     state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (ir_legal) begin
                  gpr_q[ir_rdst[IDX_W-1:0]] <= wb_data_d;
                  flags_q                   <= flags_d;
               end
               illegal_q <= ~ir_legal;
               done_q    <= 1'b1;
               state_q   <= ST_RET;
            end
            ST_MUL: begin
               if (mul_done) begin
                  gpr_q[ir_rdst[IDX_W-1:0]] <= mul_prod[DATA_W-1:0];
                  sgpr_q                    <= mul_prod[2*DATA_W-1:DATA_W];
                  flags_q                   <= {mul_prod[2*DATA_W-1], (mul_prod == '0), 2'b00};
                  done_q                    <= 1'b1;
                  state_q                   <= ST_RET;
               end
            end
            ST_RET: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dbg_data = '0;
      if (idx_ok(dbg_addr)) dbg_data = gpr_q[dbg_addr[IDX_W-1:0]];
   end

   assign instr_ready = ready_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign flags       = flags_q;
   assign sgpr        = sgpr_q;

endmodule
